// File: rtl/bp_cce_lce_req_sink.sv
// bp_cce_lce_req_sink: CCE-side terminus of the BedRock burst LCE request link.
// Holds one header plus its assembled block and hands it to the directory logic.
module bp_cce_lce_req_sink
    #(parameter int paddr_width_p  = 40
     ,parameter int lce_id_width_p = 4
     ,parameter int cce_id_width_p = 4
     ,parameter int lce_assoc_p    = 8
     ,parameter int block_width_p  = 512
     ,parameter int fill_width_p   = 64
     ,localparam int beats_lp      = block_width_p / fill_width_p
     ,localparam int cnt_width_lp  = (beats_lp > 1) ? $clog2(beats_lp) : 1
     ,localparam int way_width_lp  = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
     ,localparam int lce_req_header_width_lp =
         4 + 4 + paddr_width_p + 3 + lce_id_width_p + cce_id_width_p + way_width_lp
    )
    (input  logic                               clk_i
    ,input  logic                               reset_n_i

    ,input  logic [lce_req_header_width_lp-1:0] lce_req_header_i
    ,input  logic                               lce_req_header_v_i
    ,output logic                               lce_req_header_ready_and_o
    ,input  logic                               lce_req_has_data_i

    ,input  logic [fill_width_p-1:0]            lce_req_data_i
    ,input  logic                               lce_req_data_v_i
    ,output logic                               lce_req_data_ready_and_o
    ,input  logic                               lce_req_last_i

    ,output logic [lce_req_header_width_lp-1:0] req_header_o
    ,output logic [block_width_p-1:0]           req_data_o
    ,output logic                               req_v_o
    ,input  logic                               req_yumi_i

    ,output logic                               protocol_error_o
    );

    typedef enum logic [1:0] {
        e_reset,
        e_ready,
        e_data,
        e_send
    } state_e;

    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

    state_e                               state_r;
    state_e                               state_n;
    logic [lce_req_header_width_lp-1:0]   header_r;
    logic [block_width_p-1:0]             data_r;
    logic [block_width_p-1:0]             data_n;
    logic [cnt_width_lp-1:0]              cnt_r;
    logic                                 error_r;

    logic header_ready;
    logic data_ready;
    logic send_v;
    logic header_hs;
    logic data_hs;
    logic last_slot;
    logic overflow;

    // Ready/valid are pure state decodes so no input reaches an output.
    always_comb begin
        state_n      = state_r;
        header_ready = 1'b0;
        data_ready   = 1'b0;
        send_v       = 1'b0;
        unique case (state_r)
            e_reset: begin
                state_n = e_ready;
            end
            e_ready: begin
                header_ready = 1'b1;
                if (lce_req_header_v_i) begin
                    state_n = lce_req_has_data_i ? e_data : e_send;
                end
            end
            e_data: begin
                data_ready = 1'b1;
                if (lce_req_data_v_i && lce_req_last_i) begin
                    state_n = e_send;
                end
            end
            e_send: begin
                send_v = 1'b1;
                if (req_yumi_i) begin
                    state_n = e_ready;
                end
            end
            default: begin
                state_n = e_reset;
            end
        endcase
    end

    assign header_hs = header_ready & lce_req_header_v_i;
    assign data_hs   = data_ready & lce_req_data_v_i;
    assign last_slot = (cnt_r == last_cnt_lp);
    assign overflow  = data_hs & last_slot & ~lce_req_last_i;

    always_comb begin
        data_n = data_r;
        if (header_hs) begin
            data_n = '0;
        end
        for (int i = 0; i < beats_lp; i++) begin
            if (data_hs && (cnt_r == cnt_width_lp'(i))) begin
                data_n[i*fill_width_p +: fill_width_p] = lce_req_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_reset;
        end else begin
            state_r <= state_n;
        end
    end

    // Counter saturates on the final slot; extra beats overwrite it.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            header_r <= '0;
            data_r   <= '0;
            cnt_r    <= '0;
            error_r  <= 1'b0;
        end else begin
            data_r <= data_n;
            if (header_hs) begin
                header_r <= lce_req_header_i;
                cnt_r    <= '0;
            end
            if (data_hs && !last_slot) begin
                cnt_r <= cnt_r + cnt_width_lp'(1);
            end
            if (overflow) begin
                error_r <= 1'b1;
            end
        end
    end

    assign lce_req_header_ready_and_o = header_ready;
    assign lce_req_data_ready_and_o   = data_ready;
    assign req_v_o                    = send_v;
    assign req_header_o               = header_r;
    assign req_data_o                 = data_r;
    assign protocol_error_o           = error_r;

endmodule

// File: tb/tb_bp_cce_lce_req_sink.sv
// tb_bp_cce_lce_req_sink: directed and randomized checks of the LCE request sink
// against a slot/min-index block model.
module tb_bp_cce_lce_req_sink;

    localparam int BW    = 512;
    localparam int FW    = 64;
    localparam int BEATS = BW / FW;
    localparam int HW    = 4 + 4 + 40 + 3 + 4 + 4 + 3;

    logic          clk;
    logic          reset_n;
    logic [HW-1:0] header;
    logic          header_v;
    logic          header_ready;
    logic          has_data;
    logic [FW-1:0] data;
    logic          data_v;
    logic          data_ready;
    logic          last;
    logic [HW-1:0] req_header;
    logic [BW-1:0] req_data;
    logic          req_v;
    logic          yumi;
    logic          perr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [FW-1:0] beat_q [0:15];

    bp_cce_lce_req_sink dut (
        .clk_i                      (clk),
        .reset_n_i                  (reset_n),
        .lce_req_header_i           (header),
        .lce_req_header_v_i         (header_v),
        .lce_req_header_ready_and_o (header_ready),
        .lce_req_has_data_i         (has_data),
        .lce_req_data_i             (data),
        .lce_req_data_v_i           (data_v),
        .lce_req_data_ready_and_o   (data_ready),
        .lce_req_last_i             (last),
        .req_header_o               (req_header),
        .req_data_o                 (req_data),
        .req_v_o                    (req_v),
        .req_yumi_i                 (yumi),
        .protocol_error_o           (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_cmp++;
        if (header_ready && data_ready) begin
            n_fail++;
            $display("FAIL ready_exclusive: both readies 1 at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HW-1:0] make_hdr(input logic [3:0] t,
                                               input logic [39:0] a);
        return {t, 4'h0, a, 3'd6, 4'd1, 4'd0, 3'd2};
    endfunction

    function automatic logic [BW-1:0] model_block(input int nb);
        logic [BW-1:0] b;
        int slot;
        b = '0;
        for (int k = 0; k < nb; k++) begin
            slot = (k < BEATS) ? k : BEATS - 1;
            b[slot*FW +: FW] = beat_q[k];
        end
        return b;
    endfunction

    // Drives one message; lat counts cycles from the header edge to req_v.
    task automatic run_msg(input logic [HW-1:0] hdr, input logic hd,
                           input int nb, input int gap_at, input int gap_len,
                           output int lat, output logic tmo, output int err_beat);
        int cyc;
        tmo = 1'b0;
        err_beat = -1;
        header = hdr;
        has_data = hd;
        header_v = 1'b1;
        cyc = 0;
        while (!header_ready && cyc < 50) begin
            step();
            cyc++;
        end
        if (!header_ready) tmo = 1'b1;
        step();
        header_v = 1'b0;
        has_data = 1'b0;
        lat = 1;
        if (hd) begin
            for (int k = 0; k < nb; k++) begin
                if (k == gap_at) begin
                    data_v = 1'b0;
                    repeat (gap_len) begin
                        step();
                        lat++;
                    end
                end
                data = beat_q[k];
                last = (k == nb - 1);
                data_v = 1'b1;
                cyc = 0;
                while (!data_ready && cyc < 50) begin
                    step();
                    lat++;
                    cyc++;
                end
                if (!data_ready) tmo = 1'b1;
                step();
                lat++;
                if (perr && err_beat < 0) err_beat = k + 1;
            end
            data_v = 1'b0;
            last = 1'b0;
        end
        cyc = 0;
        while (!req_v && cyc < 100) begin
            step();
            lat++;
            cyc++;
        end
        if (!req_v) tmo = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        header_v = 1'b1;
        header = make_hdr(4'h1, 40'h12_3456_7890);
        repeat (3) begin
            step();
            n_cmp++;
            if ({header_ready, data_ready, req_v, perr} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b exp 0000",
                         {header_ready, data_ready, req_v, perr});
            end
        end
        n_cmp++;
        if (req_header !== '0 || req_data !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: hdr %h data nonzero=%0b",
                     req_header, |req_data);
        end
        header_v = 1'b0;
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (header_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: header_ready %b exp 1", header_ready);
        end
    endtask

    task automatic test_read_miss();
        logic [HW-1:0] h;
        int lat;
        logic tmo;
        int eb;
        h = make_hdr(4'h0, 40'h00_8000_0040);
        run_msg(h, 1'b0, 0, 99, 0, lat, tmo, eb);
        n_cmp++;
        if (tmo !== 1'b0 || lat != 1) begin
            n_fail++;
            $display("FAIL read_miss_lat: got %0d tmo %b exp 1", lat, tmo);
        end
        n_cmp++;
        if (req_header !== h || req_data !== '0) begin
            n_fail++;
            $display("FAIL read_miss_msg: hdr %h exp %h", req_header, h);
        end
        step();
        step();
        n_cmp++;
        if ({req_v, header_ready, data_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL read_miss_hold: got %b exp 100",
                     {req_v, header_ready, data_ready});
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        n_cmp++;
        if ({req_v, header_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL read_miss_yumi: got %b exp 01", {req_v, header_ready});
        end
    endtask

    task automatic test_uc_store();
        logic [HW-1:0] h;
        logic [BW-1:0] exp_b;
        int lat;
        logic tmo;
        int eb;
        h = make_hdr(4'h3, 40'h00_0000_1008);
        beat_q[0] = 64'hDEAD_BEEF_0123_4567;
        exp_b = model_block(1);
        run_msg(h, 1'b1, 1, 99, 0, lat, tmo, eb);
        n_cmp++;
        if (tmo !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL uc_store_lat: got %0d tmo %b exp 2", lat, tmo);
        end
        n_cmp++;
        if (req_data !== exp_b || req_header !== h) begin
            n_fail++;
            $display("FAIL uc_store_data: low %h exp %h", req_data[63:0], beat_q[0]);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_block_gap();
        logic [HW-1:0] h;
        int lat;
        logic tmo;
        int eb;
        h = make_hdr(4'h2, 40'h00_4000_0000);
        for (int i = 0; i < BEATS; i++) beat_q[i] = FW'(i * 'h1111);
        run_msg(h, 1'b1, BEATS, 3, 2, lat, tmo, eb);
        n_cmp++;
        if (tmo !== 1'b0 || lat != 11) begin
            n_fail++;
            $display("FAIL block_gap_lat: got %0d tmo %b exp 11", lat, tmo);
        end
        for (int i = 0; i < BEATS; i++) begin
            n_cmp++;
            if (req_data[i*FW +: FW] !== FW'(i * 'h1111)) begin
                n_fail++;
                $display("FAIL block_gap_slot%0d: got %h exp %h",
                         i, req_data[i*FW +: FW], FW'(i * 'h1111));
            end
        end
        n_cmp++;
        if (perr !== 1'b0) begin
            n_fail++;
            $display("FAIL block_gap_err: got %b exp 0", perr);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_data_in_ready();
        logic [HW-1:0] h;
        int lat;
        logic tmo;
        int eb;
        data = 64'hBAD0_BAD0_BAD0_BAD0;
        data_v = 1'b1;
        last = 1'b1;
        yumi = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if ({header_ready, data_ready, req_v} !== 3'b100) begin
                n_fail++;
                $display("FAIL idle_ignore: got %b exp 100",
                         {header_ready, data_ready, req_v});
            end
        end
        yumi = 1'b0;
        h = make_hdr(4'h0, 40'h00_0000_2000);
        run_msg(h, 1'b0, 0, 99, 0, lat, tmo, eb);
        data_v = 1'b0;
        last = 1'b0;
        n_cmp++;
        if (tmo !== 1'b0 || lat != 1 || req_data !== '0) begin
            n_fail++;
            $display("FAIL idle_hdr_only: lat %0d exp 1 data_nz %b", lat, |req_data);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_overflow();
        logic [HW-1:0] h;
        logic [BW-1:0] exp_b;
        int lat;
        logic tmo;
        int eb;
        h = make_hdr(4'h2, 40'h00_0000_4000);
        for (int i = 0; i < 10; i++) beat_q[i] = {$urandom, $urandom};
        exp_b = model_block(10);
        run_msg(h, 1'b1, 10, 99, 0, lat, tmo, eb);
        n_cmp++;
        if (eb != BEATS) begin
            n_fail++;
            $display("FAIL overflow_err_beat: got %0d exp %0d", eb, BEATS);
        end
        n_cmp++;
        if (tmo !== 1'b0 || lat != 11) begin
            n_fail++;
            $display("FAIL overflow_lat: got %0d tmo %b exp 11", lat, tmo);
        end
        n_cmp++;
        if (req_data !== exp_b) begin
            n_fail++;
            $display("FAIL overflow_data: slot7 %h exp %h",
                     req_data[(BEATS-1)*FW +: FW], beat_q[9]);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        step();
        n_cmp++;
        if (perr !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %b exp 1", perr);
        end
    endtask

    task automatic test_reset_mid();
        logic [HW-1:0] h;
        int lat;
        logic tmo;
        int eb;
        header = make_hdr(4'h2, 40'h00_0000_8000);
        has_data = 1'b1;
        header_v = 1'b1;
        step();
        header_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data = {$urandom, $urandom};
            data_v = 1'b1;
            last = 1'b0;
            step();
        end
        data_v = 1'b0;
        reset_n = 1'b0;
        step();
        n_cmp++;
        if ({header_ready, data_ready, req_v, perr} !== 4'b0 ||
            req_data !== '0 || req_header !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b exp 0000",
                     {header_ready, data_ready, req_v, perr});
        end
        reset_n = 1'b1;
        repeat (4) begin
            step();
            n_cmp++;
            if (req_v !== 1'b0 || perr !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet: req_v %b err %b exp 0 0", req_v, perr);
            end
        end
        h = make_hdr(4'h0, 40'h00_0000_C0C0);
        run_msg(h, 1'b0, 0, 99, 0, lat, tmo, eb);
        n_cmp++;
        if (tmo !== 1'b0 || lat != 1 || req_header !== h || perr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_next: lat %0d hdr %h exp %h", lat, req_header, h);
        end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_random();
        logic [HW-1:0] h;
        logic [BW-1:0] exp_b;
        logic hd;
        logic exp_err;
        int nb, gat, glen, exp_lat, d;
        int lat;
        logic tmo;
        int eb;
        exp_err = 1'b0;
        for (int m = 0; m < 40; m++) begin
            h = HW'({$urandom, $urandom});
            hd = ($urandom_range(0, 3) != 0);
            nb = 0;
            if (hd) nb = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 11)
                                                       : $urandom_range(1, 8);
            gat = $urandom_range(0, 12);
            glen = $urandom_range(0, 3);
            for (int k = 0; k < nb; k++) beat_q[k] = {$urandom, $urandom};
            exp_b = model_block(nb);
            exp_lat = hd ? 1 + nb + ((gat < nb) ? glen : 0) : 1;
            exp_err = exp_err | (nb > BEATS);
            run_msg(h, hd, nb, gat, glen, lat, tmo, eb);
            n_cmp++;
            if (tmo !== 1'b0 || lat != exp_lat) begin
                n_fail++;
                $display("FAIL rand%0d_lat: got %0d tmo %b exp %0d", m, lat, tmo, exp_lat);
            end
            n_cmp++;
            if (req_header !== h || req_data !== exp_b) begin
                n_fail++;
                $display("FAIL rand%0d_msg: hdr %h exp %h nb %0d", m, req_header, h, nb);
            end
            n_cmp++;
            if (perr !== exp_err) begin
                n_fail++;
                $display("FAIL rand%0d_err: got %b exp %b", m, perr, exp_err);
            end
            d = $urandom_range(0, 3);
            repeat (d) begin
                step();
                n_cmp++;
                if (req_v !== 1'b1 || req_header !== h) begin
                    n_fail++;
                    $display("FAIL rand%0d_hold: req_v %b", m, req_v);
                end
            end
            yumi = 1'b1;
            step();
            yumi = 1'b0;
            n_cmp++;
            if ({req_v, header_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL rand%0d_yumi: got %b exp 01", m, {req_v, header_ready});
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        header = '0;
        header_v = 1'b0;
        has_data = 1'b0;
        data = '0;
        data_v = 1'b0;
        last = 1'b0;
        yumi = 1'b0;
        test_reset();
        test_read_miss();
        test_uc_store();
        test_block_gap();
        test_data_in_ready();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
